// File: rtl/hwpe_stream_realigner_if.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_stream_intf_stream
// Description : Valid/ready streaming bus carrying one DATA_WIDTH-bit word
//               plus a per-byte strobe.
//               source : drives valid, data, strb; samples ready
//               sink   : samples valid, data, strb; drives ready
//               master/slave are aliases of source/sink.
// Revision    : 1.0 - initial release
// ============================================================================
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                      valid;
    logic                      ready;
    logic [DATA_WIDTH-1:0]     data;
    logic [DATA_WIDTH/8-1:0]   strb;

    modport source (output valid, output data, output strb, input  ready);
    modport sink   (input  valid, input  data, input  strb, output ready);
    modport master (output valid, output data, output strb, input  ready);
    modport slave  (input  valid, input  data, input  strb, output ready);

endinterface
`default_nettype wire

// File: rtl/hwpe_stream_realigner.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_stream_realigner
// Description : Realigns a byte stream whose first valid byte sits at a byte
//               offset inside input word 0 so that output word 0 starts with
//               that byte. The last output word carries a partial strobe and
//               has its unused bytes forced to zero.
// Ports       : clk_i     - clock
//               rst_i     - synchronous active-high reset
//               clear_i   - synchronous soft clear (same effect as rst_i)
//               start_i   - one-cycle transfer launch (sampled in IDLE only)
//               offset_i  - byte offset of first valid byte in input word 0
//               len_i     - transfer length in bytes (0 is ignored)
//               busy_o    - transfer in progress
//               done_o    - one-cycle pulse after the final output handshake
//               stream_i  - misaligned input words (strb ignored)
//               stream_o  - aligned output words
// Revision    : 1.0 - initial release
// ============================================================================
module hwpe_stream_realigner #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  wire logic                                 clk_i,
    input  wire logic                                 rst_i,
    input  wire logic                                 clear_i,
    input  wire logic                                 start_i,
    input  wire logic [$clog2(DATA_WIDTH/8)-1:0]      offset_i,
    input  wire logic [LEN_WIDTH-1:0]                 len_i,
    output logic                                      busy_o,
    output logic                                      done_o,
    hwpe_stream_intf_stream.sink                      stream_i,
    hwpe_stream_intf_stream.source                    stream_o
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned SH_W  = OFF_W + 3;
    // One extra bit so offset + len + NB-1 cannot overflow.
    localparam int unsigned CNT_W = LEN_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PASS   = 3'd1,
        S_PRIME  = 3'd2,
        S_STREAM = 3'd3,
        S_FLUSH  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_W-1:0]        r_cnt_in;
    logic [CNT_W-1:0]        r_cnt_out;
    logic [DATA_WIDTH-1:0]   r_buf;
    logic [OFF_W-1:0]        r_off;
    logic [OFF_W-1:0]        r_rem;
    logic                    r_done;

    logic                    w_kill;
    logic                    w_start_ok;
    logic                    w_in_ready;
    logic                    w_out_valid;
    logic                    w_in_hs;
    logic                    w_out_hs;
    logic                    w_last_out;
    logic [DATA_WIDTH-1:0]   w_data_raw;
    logic [DATA_WIDTH-1:0]   w_buf_shifted;
    logic [DATA_WIDTH-1:0]   w_stream_word;
    logic [SH_W-1:0]         w_sh_lo;
    logic [SH_W-1:0]         w_sh_hi;
    logic [CNT_W-1:0]        w_n_in;
    logic [CNT_W-1:0]        w_n_out;
    logic [OFF_W-1:0]        w_rem;
    logic [NB-1:0]           w_last_strb;
    logic [NB-1:0]           w_strb;
    logic [DATA_WIDTH-1:0]   w_byte_mask;

    assign w_kill = rst_i | clear_i;

    // Word counts for the transfer being launched.
    assign w_n_in  = (CNT_W'(len_i) + CNT_W'(offset_i) + CNT_W'(NB - 1)) / CNT_W'(NB);
    assign w_n_out = (CNT_W'(len_i) + CNT_W'(NB - 1)) / CNT_W'(NB);
    assign w_rem   = OFF_W'(len_i % LEN_WIDTH'(NB));

    // Byte shifts. The high shift is only meaningful for a non-zero offset;
    // forcing it to zero otherwise keeps every shift below DATA_WIDTH.
    assign w_sh_lo = SH_W'(r_off) << 3;
    assign w_sh_hi = (r_off == '0) ? '0 : ((SH_W'(NB) - SH_W'(r_off)) << 3);

    assign w_buf_shifted = r_buf >> w_sh_lo;
    assign w_stream_word = w_buf_shifted | (stream_i.data << w_sh_hi);

    assign w_last_out = (r_cnt_out == CNT_W'(1));

    generate
        for (genvar b = 0; b < NB; b++) begin : g_strb
            assign w_last_strb[b]          = (r_rem == '0) || (OFF_W'(b) < r_rem);
            assign w_byte_mask[8*b +: 8]   = {8{w_strb[b]}};
        end
    endgenerate

    assign w_strb = w_last_out ? w_last_strb : '1;

    // Next state and handshake control.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_data_raw   = '0;
        w_start_ok   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i && (len_i != '0)) begin
                    w_start_ok   = 1'b1;
                    w_state_next = (offset_i == '0) ? S_PASS : S_PRIME;
                end
            end
            S_PASS: begin
                w_in_ready  = stream_o.ready;
                w_out_valid = stream_i.valid;
                w_data_raw  = stream_i.data;
                if (stream_i.valid && stream_o.ready && w_last_out) begin
                    w_state_next = S_IDLE;
                end
            end
            S_PRIME: begin
                w_in_ready = 1'b1;
                if (stream_i.valid) begin
                    w_state_next = (r_cnt_in == CNT_W'(1)) ? S_FLUSH : S_STREAM;
                end
            end
            S_STREAM: begin
                w_in_ready  = stream_o.ready;
                w_out_valid = stream_i.valid;
                w_data_raw  = w_stream_word;
                if (stream_i.valid && stream_o.ready && (r_cnt_in == CNT_W'(1))) begin
                    w_state_next = w_last_out ? S_IDLE : S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_out_valid = 1'b1;
                w_data_raw  = w_buf_shifted;
                if (stream_o.ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // A reset or clear cycle must never complete a handshake.
        if (w_kill) begin
            w_in_ready  = 1'b0;
            w_out_valid = 1'b0;
        end
    end

    assign w_in_hs  = stream_i.valid & w_in_ready;
    assign w_out_hs = w_out_valid & stream_o.ready;

    always_ff @(posedge clk_i) begin
        if (w_kill) begin
            r_state   <= S_IDLE;
            r_cnt_in  <= '0;
            r_cnt_out <= '0;
            r_buf     <= '0;
            r_off     <= '0;
            r_rem     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_out_hs & w_last_out;
            if (w_start_ok) begin
                r_off     <= offset_i;
                r_rem     <= w_rem;
                r_cnt_in  <= w_n_in;
                r_cnt_out <= w_n_out;
            end
            if (w_in_hs) begin
                r_buf    <= stream_i.data;
                r_cnt_in <= r_cnt_in - CNT_W'(1);
            end
            if (w_out_hs) begin
                r_cnt_out <= r_cnt_out - CNT_W'(1);
            end
        end
    end

    assign stream_i.ready = w_in_ready;
    assign stream_o.valid = w_out_valid;
    assign stream_o.data  = w_data_raw & w_byte_mask;
    assign stream_o.strb  = w_strb;

    assign busy_o = (r_state != S_IDLE) && !w_kill;
    assign done_o = r_done && !w_kill;

endmodule
`default_nettype wire

// File: tb/tb_hwpe_stream_realigner.sv
`default_nettype none
// ============================================================================
// Module      : tb_hwpe_stream_realigner
// Description : Self-checking bench for hwpe_stream_realigner (32-bit words).
//               A table of transfers is replayed; expected output words are
//               queued at launch and popped by a monitor on each output
//               handshake. Backpressure, zero-length, start-while-busy and
//               clear-abort sequences are written out by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hwpe_stream_realigner;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        start;
    logic [1:0]  offset;
    logic [15:0] len;
    logic        busy;
    logic        done;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) s_in ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) s_out ();

    hwpe_stream_realigner #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (clear),
        .start_i  (start),
        .offset_i (offset),
        .len_i    (len),
        .busy_o   (busy),
        .done_o   (done),
        .stream_i (s_in),
        .stream_o (s_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]        off;
        logic [15:0]       len;
        int                n_in;
        logic [2:0][31:0]  din;
        int                n_out;
        logic [1:0][31:0]  dout;
        logic [1:0][3:0]   sout;
    } vec_t;

    vec_t         vecs [6];
    logic [35:0]  exp_q [$];
    int           checks = 0;
    int           failures = 0;
    int           done_cnt = 0;
    int           out_hs_cnt = 0;
    int           cyc = 0;
    int           last_hs_cyc = -10;
    logic         stalled = 1'b0;
    logic [35:0]  held;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    function automatic vec_t mk(input logic [1:0] off, input logic [15:0] l, input int ni,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input int no, input logic [31:0] o0, input logic [3:0] s0,
                                input logic [31:0] o1, input logic [3:0] s1);
        vec_t v;
        v.off = off; v.len = l; v.n_in = ni;
        v.din[0] = d0; v.din[1] = d1; v.din[2] = d2;
        v.n_out = no;
        v.dout[0] = o0; v.sout[0] = s0;
        v.dout[1] = o1; v.sout[1] = s1;
        return v;
    endfunction

    // Output monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [35:0] e;
        cyc = cyc + 1;
        if (s_out.valid) begin
            if (stalled) chk("out_stable_under_stall", {s_out.data, s_out.strb}, held);
        end
        if (s_out.valid && !s_out.ready) begin
            chk("no_input_during_stall", {63'd0, s_in.ready}, 64'd0);
            stalled = 1'b1;
            held    = {s_out.data, s_out.strb};
        end else begin
            stalled = 1'b0;
        end
        if (s_out.valid && s_out.ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {s_out.data, s_out.strb}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", {32'd0, s_out.data}, {32'd0, e[35:4]});
                chk("out_strb", {60'd0, s_out.strb}, {60'd0, e[3:0]});
            end
            out_hs_cnt  = out_hs_cnt + 1;
            last_hs_cyc = cyc;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            chk("done_one_after_last_hs", 64'(cyc), 64'(last_hs_cyc + 1));
        end
    end

    task automatic drive_words(input vec_t v, input int n);
        for (int i = 0; i < n; i++) begin
            logic acc;
            int   t;
            s_in.valid = 1'b1;
            s_in.data  = v.din[i];
            acc = 1'b0;
            t   = 0;
            while (!acc && t < 50) begin
                @(negedge clk);
                acc = s_in.ready;
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) begin
                chk("input_accept_timeout", 64'(i), 64'hFFFF);
                break;
            end
        end
        s_in.valid = 1'b0;
        s_in.data  = '0;
    endtask

    task automatic drive_ready(input int after, input int n);
        s_out.ready = 1'b1;
        if (n == 0) return;
        for (int t = 0; t < 200 && out_hs_cnt < after; t++) begin
            @(posedge clk);
            #1;
        end
        s_out.ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        s_out.ready = 1'b1;
    endtask

    // Called at posedge+1; launches the transfer in the current cycle.
    task automatic run_vec(input vec_t v, input int stall_after, input int stall_len);
        for (int i = 0; i < v.n_out; i++) exp_q.push_back({v.dout[i], v.sout[i]});
        done_cnt   = 0;
        out_hs_cnt = 0;
        start  = 1'b1;
        offset = v.off;
        len    = v.len;
        @(negedge clk);
        chk("idle_before_start", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        fork
            drive_words(v, v.n_in);
            drive_ready(stall_after, stall_len);
            begin
                @(negedge clk);
                chk("busy_after_start", {63'd0, busy}, 64'd1);
            end
        join
        for (int t = 0; t < 40 && done_cnt == 0; t++) @(negedge clk);
        if (done_cnt == 0) chk("done_timeout", 64'd0, 64'd1);
        repeat (2) @(negedge clk);
        chk("done_pulse_count", 64'(done_cnt), 64'd1);
        chk("all_outputs_seen", 64'(exp_q.size()), 64'd0);
        chk("idle_after_done", {63'd0, busy}, 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; start = 1'b0; offset = '0; len = '0;
        s_in.valid = 1'b0; s_in.data = '0; s_in.strb = '0; s_out.ready = 1'b0;

        vecs[0] = mk(2'd1, 16'd8, 3, 32'h03020100, 32'h07060504, 32'h0B0A0908,
                     2, 32'h04030201, 4'b1111, 32'h08070605, 4'b1111);
        vecs[1] = mk(2'd3, 16'd5, 2, 32'h03020100, 32'h07060504, 32'h0,
                     2, 32'h06050403, 4'b1111, 32'h00000007, 4'b0001);
        vecs[2] = mk(2'd0, 16'd6, 2, 32'h03020100, 32'h07060504, 32'h0,
                     2, 32'h03020100, 4'b1111, 32'h00000504, 4'b0011);
        vecs[3] = mk(2'd2, 16'd1, 1, 32'h03020100, 32'h0, 32'h0,
                     1, 32'h00000002, 4'b0001, 32'h0, 4'b0000);
        vecs[4] = mk(2'd2, 16'd7, 3, 32'h03020100, 32'h07060504, 32'h0B0A0908,
                     2, 32'h05040302, 4'b1111, 32'h00080706, 4'b0111);
        vecs[5] = mk(2'd1, 16'd3, 1, 32'h03020100, 32'h0, 32'h0,
                     1, 32'h00030201, 4'b0111, 32'h0, 4'b0000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",  {63'd0, busy},        64'd0);
        chk("rst_done",  {63'd0, done},        64'd0);
        chk("rst_valid", {63'd0, s_out.valid}, 64'd0);
        chk("rst_ready", {63'd0, s_in.ready},  64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], 0, 0);

        // Backpressure: output ready low for 3 cycles after the first output.
        run_vec(vecs[0], 1, 3);

        // Zero-length start is ignored.
        start = 1'b1; offset = 2'd1; len = 16'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("len0_ignored_busy",  {63'd0, busy},       64'd0);
        chk("len0_ignored_ready", {63'd0, s_in.ready}, 64'd0);
        @(posedge clk);
        #1;

        // Clear mid-STREAM, with a start attempted while busy, then restart.
        exp_q.push_back({32'h04030201, 4'b1111});
        done_cnt = 0;
        s_out.ready = 1'b1;
        start = 1'b1; offset = 2'd1; len = 16'd8;
        @(posedge clk);
        #1;
        start = 1'b1; offset = 2'd0; len = 16'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        drive_words(vecs[0], 2);
        clear = 1'b1;
        @(negedge clk);
        chk("clear_busy_low", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clear_no_done", 64'(done_cnt), 64'd0);
        chk("clear_outputs_before_abort", 64'(exp_q.size()), 64'd0);
        run_vec(vecs[2], 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/hwpe_stream_realigner.md
HWPE_STREAM_REALIGNER -- requirements
Module: hwpe_stream_realigner

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream width in bits; multiple of 8, at least 16; NB = DATA_WIDTH/8.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, width of the byte-length field.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk_i, input, 1 bit: clock.
REQ-005 Port rst_i, input, 1 bit: synchronous active-high reset.
REQ-006 Port clear_i, input, 1 bit: synchronous soft clear, same effect as rst_i.
REQ-007 Port start_i, input, 1 bit: single-cycle transfer launch.
REQ-008 Port offset_i, input, $clog2(NB) bits: byte offset of the first valid byte in input word 0; sampled on start.
REQ-009 Port len_i, input, LEN_WIDTH bits: transfer length in bytes; sampled on start.
REQ-010 Port busy_o, output, 1 bit: transfer in progress.
REQ-011 Port done_o, output, 1 bit: one-cycle completion pulse.
REQ-012 Port stream_i, hwpe_stream_intf_stream.sink, DATA_WIDTH: misaligned input words; stream_i.strb is ignored.
REQ-013 Port stream_o, hwpe_stream_intf_stream.source, DATA_WIDTH: aligned output words.

Function
REQ-014 SHALL compute N_in = ceil((offset+len)/NB) and N_out = ceil(len/NB) on start, held in down-counters.
REQ-015 SHALL implement the states IDLE, PASS, PRIME, STREAM and FLUSH.
REQ-016 In IDLE: start_i with len_i != 0 and offset_i == 0 SHALL go to PASS; start_i with len_i != 0 and offset_i != 0 SHALL go to PRIME.
REQ-017 In IDLE, start_i with len_i == 0 SHALL be ignored; start_i while busy_o = 1 SHALL be ignored.
REQ-018 In PASS, stream_o.valid SHALL equal stream_i.valid, stream_i.ready SHALL equal stream_o.ready, and output data SHALL equal input data.
REQ-019 In PRIME, stream_i.ready SHALL be 1 and stream_o.valid SHALL be 0.
REQ-020 In PRIME, the input handshake SHALL store the word into buf_q and decrement the input counter.
REQ-021 PRIME SHALL then go to STREAM if input words remain, else to FLUSH.
REQ-022 In STREAM, stream_o.valid SHALL equal stream_i.valid and stream_i.ready SHALL equal stream_o.ready (zero-cycle combinational path).
REQ-023 In STREAM, stream_o.data SHALL equal (buf_q >> 8*off) | (stream_i.data << 8*(NB-off)).
REQ-024 In STREAM, each handshake SHALL load buf_q with stream_i.data and decrement both counters.
REQ-025 After the last input word in STREAM: if output words remain, SHALL go to FLUSH; else SHALL go to IDLE.
REQ-026 In FLUSH, stream_o.valid SHALL be 1, stream_i.ready SHALL be 0, and stream_o.data SHALL equal buf_q >> 8*off.
REQ-027 In FLUSH, the output handshake SHALL return the block to IDLE.
REQ-028 On every output word except the last, stream_o.strb SHALL be '1.
REQ-029 On the last output word, with r = len mod NB, stream_o.strb SHALL have the low r bits set, or all bits set if r == 0.
REQ-030 On the last output word, bytes outside the strobe SHALL be driven to zero.
REQ-031 stream_o.valid SHALL hold, with data/strb stable, until stream_o.ready; there SHALL be no input handshake in PRIME/STREAM without the matching rule above.
REQ-032 done_o SHALL pulse for exactly one cycle, the cycle after the final output handshake.
REQ-033 busy_o SHALL be 1 in every state except IDLE.
REQ-034 In IDLE, stream_i.ready and stream_o.valid SHALL be 0.
REQ-035 Offset arithmetic SHALL be performed in $clog2(NB)+3 bits; shift amounts SHALL never reach DATA_WIDTH.

Reset
REQ-036 On rst_i or clear_i (synchronous), the block SHALL enter IDLE and clear counters, buf_q, offset and length.
REQ-037 On rst_i or clear_i, busy_o, done_o, stream_o.valid and stream_i.ready SHALL all be 0.
REQ-038 clear_i mid-transfer SHALL abort without a done_o pulse; a new start SHALL be accepted the next cycle.

Verification (DATA_WIDTH=32)
REQ-039 SHALL test: offset=1, len=8, inputs 0x03020100, 0x07060504, 0x0B0A0908 -> outputs 0x04030201 (strb 1111), 0x08070605 (strb 1111); no FLUSH; done_o pulses once.
REQ-040 SHALL test: offset=3, len=5, inputs 0x03020100, 0x07060504 -> outputs 0x06050403 (strb 1111), then FLUSH 0x00000007 (strb 0001).
REQ-041 SHALL test: offset=0, len=6, inputs 0x03020100, 0x07060504 -> outputs 0x03020100 (strb 1111), 0x00000504 (strb 0011) via PASS.
REQ-042 SHALL test: offset=2, len=1, input 0x03020100 -> PRIME then FLUSH, output 0x00000002 (strb 0001).
REQ-043 SHALL test backpressure: REQ-039 stimulus with stream_o.ready low for 3 cycles mid-stream -> no input consumed, output data stable, identical final results.
REQ-044 SHALL test clear: clear_i in STREAM of REQ-039 after one output -> IDLE next cycle, busy_o=0, no done_o; immediate restart of REQ-041 -> correct outputs.
